// File: rtl/avalon_ram_pkg.sv
// avalon_ram_pkg
// Shared constants, wait-state FSM encoding and the byte-lane merge helper
// for the Avalon-MM RAM slave.
package avalon_ram_pkg;

    localparam int WORD_W            = 32;
    localparam int BYTE_LANES        = 4;
    localparam int DEFAULT_ADDR_BITS = 8;

    typedef enum logic {
        WS_IDLE = 1'b0,
        WS_ACK  = 1'b1
    } wait_state_e;

    // Replace only the enabled byte lanes of old_word with new_word.
    // Lane i covers bits [8i+7:8i] (little-endian lane order).
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0]     old_word,
        input logic [WORD_W-1:0]     new_word,
        input logic [BYTE_LANES-1:0] lane_en
    );
        logic [WORD_W-1:0] result;
        result = old_word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (lane_en[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_ram_wait_ctrl.sv
// avalon_ram_wait_ctrl
// Inserts exactly one wait cycle at the start of every Avalon transfer.
// Ports:
//   clk         - bus clock
//   rst_n       - asynchronous active-low reset
//   read, write - Avalon strobes from the master
//   waitrequest - stall; high on the first cycle of each transfer
//
// state   | meaning
// --------+-------------------------------------------------------------
// WS_IDLE | no transfer pending; a new read/write raises waitrequest
// WS_ACK  | second cycle of a transfer; waitrequest low, transfer completes
module avalon_ram_wait_ctrl
    import avalon_ram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic read,
    input  logic write,
    output logic waitrequest
);

    wait_state_e state_q;
    wait_state_e state_d;
    logic        wait_comb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_comb = 1'b0;
        case (state_q)
            WS_IDLE: begin
                if (read || write) begin
                    wait_comb = 1'b1;
                    state_d   = WS_ACK;
                end
            end
            WS_ACK: begin
                // Transfer completes on this edge; a strobe still held next
                // cycle is a new transfer and stalls again.
                state_d = WS_IDLE;
            end
            default: state_d = WS_IDLE;
        endcase
    end

    // Reset must force the stall low even if a strobe is held.
    assign waitrequest = rst_n & wait_comb;

endmodule

// File: rtl/avalon_ram.sv
// avalon_ram
// Avalon-MM 32-bit RAM slave with byte-lane writes, a level-sensitive
// backdoor loader and an optional one-cycle wait state (RAM_WAITSTATE_EN).
// Ports:
//   clk          - bus clock; bus writes land on its rising edge
//   RAM_Reset    - asynchronous active-low reset, clears every word
//   address      - byte address; word = address[ADDR_BITS-1:2]
//   write, read  - Avalon strobes (both high = write, read sees old data)
//   waitrequest  - Avalon stall (tied low unless RAM_WAITSTATE_EN)
//   writedata    - write data
//   byteenable   - per-lane write enables, lane 0 = bits [7:0]
//   readdata     - addressed word while an accepted read is active, else 0
//   instruction  - backdoor load data
//   inst_input   - backdoor load enable, level-sensitive
//   inst_addr    - backdoor byte address; word = inst_addr[7:2]
module avalon_ram
    import avalon_ram_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  RAM_Reset,
    input  logic [31:0]           address,
    input  logic                  write,
    input  logic                  read,
    output logic                  waitrequest,
    input  logic [WORD_W-1:0]     writedata,
    input  logic [BYTE_LANES-1:0] byteenable,
    output logic [WORD_W-1:0]     readdata,
    input  logic [WORD_W-1:0]     instruction,
    input  logic                  inst_input,
    input  logic [7:0]            inst_addr
);

    localparam int IDX_W = ADDR_BITS - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic                 wait_req;
    logic                 bus_we;
    logic [IDX_W-1:0]     bus_idx;
    logic [IDX_W-1:0]     inst_idx;
    logic [WORD_W-1:0]    merged_word;
    logic [WORD_W-1:0]    word_eff [DEPTH];
    logic                 load_hit [DEPTH];
    logic                 unused_bits;

`ifdef RAM_WAITSTATE_EN
    avalon_ram_wait_ctrl u_wait_ctrl (
        .clk         (clk),
        .rst_n       (RAM_Reset),
        .read        (read),
        .write       (write),
        .waitrequest (wait_req)
    );
`else
    assign wait_req = 1'b0;
`endif

    assign waitrequest = wait_req;
    assign bus_idx     = address[ADDR_BITS-1:2];
    assign bus_we      = write && !wait_req;
    assign merged_word = merge_bytes(word_eff[bus_idx], writedata, byteenable);

    generate
        if (IDX_W <= 6) begin : g_inst_idx_narrow
            assign inst_idx = inst_addr[IDX_W+1:2];
        end else begin : g_inst_idx_wide
            assign inst_idx = IDX_W'(inst_addr[7:2]);
        end
    endgenerate

    // Upper address bits alias and the low two bits select bytes only.
    assign unused_bits = ^{address, inst_addr};

    // Each word is a clocked copy (bus writes) plus a transparent-latch copy
    // (backdoor loads). A one-bit tag pair records which copy was written
    // last: a load makes the tags differ, a bus write makes them equal.
    // This keeps the clocked path a plain flop and the clock-free load path
    // a plain latch, with no storage element driven from both.
    generate
        for (genvar w = 0; w < DEPTH; w++) begin : g_word
            logic [WORD_W-1:0] ff_val;
            logic              ff_tag;
            logic [WORD_W-1:0] bd_val;
            logic              bd_tag;

            assign load_hit[w] = inst_input && (inst_idx == IDX_W'(w));
            assign word_eff[w] = (bd_tag ^ ff_tag) ? bd_val : ff_val;

            always_latch begin
                if (!RAM_Reset) begin
                    bd_val = '0;
                    bd_tag = 1'b0;
                end else if (load_hit[w]) begin
                    bd_val = instruction;
                    bd_tag = ~ff_tag;
                end
            end

            // A backdoor load to the same word wins over the bus write.
            always_ff @(posedge clk or negedge RAM_Reset) begin
                if (!RAM_Reset) begin
                    ff_val <= '0;
                    ff_tag <= 1'b0;
                end else if (bus_we && (bus_idx == IDX_W'(w)) && !load_hit[w]) begin
                    ff_val <= merged_word;
                    ff_tag <= bd_tag;
                end
            end
        end
    endgenerate

    always_comb begin
        readdata = '0;
        if (RAM_Reset && read && !wait_req) begin
            readdata = word_eff[bus_idx];
        end
    end

endmodule

// File: tb/tb_avalon_ram.sv
module tb_avalon_ram;

    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;

    int compared   = 0;
    int mismatched = 0;

    // Reference memory: 64 words, indexed by (byte address / 4) mod 64.
    logic [31:0] model [64];

    avalon_ram dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .instruction (instruction),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
    endtask

    // Bus transfer: write (optionally with read held too) or pure read.
    task automatic xfer(input string tag, input logic [31:0] a, input logic wr,
                        input logic rd, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] got;
        logic        done;
        @(negedge clk);
        address = a; write = wr; read = rd; writedata = d; byteenable = be;
        done = 1'b0; got = 32'h0;
        for (int c = 0; c < 6 && !done; c++) begin
            #1;
            if (!waitrequest) begin
                done = 1'b1;
                got  = readdata;
            end
            @(posedge clk);
        end
        #1;
        write = 1'b0; read = 1'b0;
        check({tag, " accept"}, 32'(done), 32'd1);
        if (rd) check(tag, got, model[widx(a)]);
        if (wr && done) model[widx(a)] = apply_be(model[widx(a)], d, be);
        #1;
        check({tag, " idle rd"}, readdata, 32'h0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        xfer(tag, a, 1'b0, 1'b1, 32'h0, 4'($urandom));
    endtask

    task automatic do_write(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        xfer(tag, a, 1'b1, 1'b0, d, be);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        inst_addr = a; instruction = d; inst_input = 1'b1;
        #1 inst_input = 1'b0;
        model[a / 4] = d;
    endtask

    initial begin
        logic [31:0] ra, rd32;
        logic [3:0]  rbe;
        logic [7:0]  la;
        RAM_Reset = 1'b0; address = 32'h0; write = 1'b0; read = 1'b0;
        writedata = 32'h0; byteenable = 4'h0; instruction = 32'h0;
        inst_input = 1'b0; inst_addr = 8'h0;
        clear_model();

        // During reset: a read and a backdoor load must both be ignored.
        #2;
        read = 1'b1; address = 32'h0000_0014;
        inst_addr = 8'h14; instruction = 32'h0000_0055; inst_input = 1'b1;
        #1;
        check("rst readdata", readdata, 32'h0);
        check("rst waitreq", 32'(waitrequest), 32'h0);
        inst_input = 1'b0; read = 1'b0;
        @(negedge clk);
        RAM_Reset = 1'b1;

        do_read("post-rst 0x00", 32'h0000_0000);
        do_read("post-rst 0x14", 32'h0000_0014);
        do_read("post-rst 0xFC", 32'h0000_00FC);

        // Two backdoor loads one time unit apart, no clock edge between.
        @(negedge clk);
        inst_input = 1'b1; inst_addr = 8'h04; instruction = 32'h2404_FEDC;
        #1 inst_addr = 8'h08; instruction = 32'h0004_2100;
        #1 inst_input = 1'b0;
        model[1] = 32'h2404_FEDC;
        model[2] = 32'h0004_2100;
        do_read("load 0x04", 32'h0000_0004);
        do_read("load 0x08", 32'h0000_0008);
        do_read("alias 0xBFC00004", 32'hBFC0_0004);

`ifdef RAM_WAITSTATE_EN
        // One wait cycle, then data; holding read makes a second transfer.
        @(negedge clk);
        address = 32'h0000_0004; read = 1'b1;
        #1;
        check("ws first wait", 32'(waitrequest), 32'h1);
        check("ws first rd gated", readdata, 32'h0);
        @(posedge clk); #1;
        check("ws ack wait", 32'(waitrequest), 32'h0);
        check("ws ack data", readdata, 32'h2404_FEDC);
        @(posedge clk); #1;
        check("ws b2b wait", 32'(waitrequest), 32'h1);
        @(posedge clk); #1;
        check("ws b2b ack", 32'(waitrequest), 32'h0);
        @(posedge clk); #1;
        read = 1'b0;
`endif

        // Byte-lane write.
        do_write("w 0x10 full", 32'h0000_0010, 32'h1122_3344, 4'hF);
        do_write("w 0x10 lanes", 32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
        do_read("r 0x10 lanes", 32'h0000_0010);
        check("lane model", model[4], 32'h11BB_33DD);

        // Read and write together: old data returned, new data stored.
        xfer("rw 0x10", 32'h0000_0010, 1'b1, 1'b1, 32'h0102_0304, 4'b1010);
        do_read("r 0x10 after rw", 32'h0000_0010);

        // Backdoor load beats a bus write to the same word.
        @(negedge clk);
        address = 32'h0000_000C; writedata = 32'hDEAD_BEEF; byteenable = 4'hF; write = 1'b1;
        inst_addr = 8'h0C; instruction = 32'hCAFE_F00D; inst_input = 1'b1;
        for (int c = 0; c < 3; c++) @(posedge clk);
        #1;
        write = 1'b0; inst_input = 1'b0;
        model[3] = 32'hCAFE_F00D;
        do_read("load beats write", 32'h0000_000C);

        // Randomised traffic against the model.
        for (int n = 0; n < 60; n++) begin
            ra   = $urandom;
            rd32 = $urandom;
            rbe  = 4'($urandom);
            la   = 8'($urandom);
            case ($urandom_range(0, 3))
                0: do_write("rnd wr", ra, rd32, rbe);
                1: do_read("rnd rd", ra);
                2: do_load(la, rd32);
                default: xfer("rnd rw", ra, 1'b1, 1'b1, rd32, rbe);
            endcase
        end
        for (int i = 0; i < 64; i += 7) do_read("rnd sweep", 32'(i * 4) | 32'h8000_0000);

        // Reset in the middle of a write: abandoned, memory cleared.
        @(negedge clk);
        address = 32'h0000_0020; writedata = 32'h1234_5678; byteenable = 4'hF; write = 1'b1;
        #1;
`ifdef RAM_WAITSTATE_EN
        check("mid-write stall", 32'(waitrequest), 32'h1);
`endif
        RAM_Reset = 1'b0;
        #1;
        check("rst mid-write wait", 32'(waitrequest), 32'h0);
        @(posedge clk); #1;
        write = 1'b0;
        clear_model();
        @(negedge clk);
        RAM_Reset = 1'b1;
        do_read("rst abandoned 0x20", 32'h0000_0020);
        do_read("rst cleared 0x04", 32'h0000_0004);
        do_read("rst cleared 0x10", 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
